// File: rtl/mips_run_control.sv
// Clock-enable and reset sequencer for the 5-stage MIPS pipeline core.
// Stretches reset release, then runs the core in halt, free-run or step-N mode.
module mips_run_control #(
  parameter int RST_HOLD = 4,
  parameter int STEP_W   = 16,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_mode,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_step_count,
  input  logic              i_halt_req,
  input  logic              i_soft_rst,
  input  logic              i_cnt_clr,
  output logic              o_cpu_reset,
  output logic              o_cpu_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_HOLD, S_IDLE, S_RUN, S_STEP} state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [HW-1:0]     r_holdCnt;
  logic [STEP_W-1:0] r_remaining;
  logic              r_cpuReset;
  logic              r_cpuEn;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_cycleCount;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= 1'b1;
      r_sync2 <= r_sync1;
    end
  end

  // soft_rst outranks every state transition and silently kills any run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_HOLD;
      r_holdCnt   <= '0;
      r_remaining <= '0;
      r_cpuReset  <= 1'b1;
      r_cpuEn     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_soft_rst) begin
        r_state     <= S_HOLD;
        r_holdCnt   <= '0;
        r_remaining <= '0;
        r_cpuReset  <= 1'b1;
        r_cpuEn     <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_HOLD: begin
            if (r_sync2) begin
              if (r_holdCnt == HOLD_LAST) begin
                r_cpuReset <= 1'b0;
                r_holdCnt  <= '0;
                r_state    <= S_IDLE;
              end else begin
                r_holdCnt <= r_holdCnt + 1'b1;
              end
            end
          end
          S_IDLE: begin
            if (i_start && i_mode == 2'b01) begin
              r_state <= S_RUN;
              r_cpuEn <= 1'b1;
              r_busy  <= 1'b1;
            end else if (i_start && i_mode == 2'b10) begin
              if (i_step_count == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state     <= S_STEP;
                r_remaining <= i_step_count;
                r_cpuEn     <= 1'b1;
                r_busy      <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (i_halt_req) begin
              r_state <= S_IDLE;
              r_cpuEn <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_STEP: begin
            if (i_halt_req || r_remaining == STEP_W'(1)) begin
              r_state     <= S_IDLE;
              r_remaining <= '0;
              r_cpuEn     <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_remaining <= r_remaining - 1'b1;
            end
          end
          default: r_state <= S_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycleCount <= '0;
    end else if (i_cnt_clr) begin
      r_cycleCount <= '0;
    end else if (r_cpuEn && r_cycleCount != {CNT_W{1'b1}}) begin
      r_cycleCount <= r_cycleCount + 1'b1;
    end
  end

  assign o_cpu_reset   = r_cpuReset;
  assign o_cpu_en      = r_cpuEn;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycleCount;

endmodule

// File: tb/tb_mips_run_control.sv
// Randomised and directed bench for mips_run_control against a cycle-level
// behavioural model; a second instance with a 4-bit counter exercises saturation.
module tb_mips_run_control;

  localparam int RST_HOLD = 4;
  localparam int STEP_W   = 16;
  localparam int CNT_W    = 32;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              start = 1'b0;
  logic [STEP_W-1:0] stepCount = '0;
  logic              halt = 1'b0;
  logic              softRst = 1'b0;
  logic              cntClr = 1'b0;

  logic              cpuReset, cpuEn, busy, done;
  logic [CNT_W-1:0]  cycleCount;
  logic              sCpuReset, sCpuEn, sBusy, sDone;
  logic [3:0]        sCycleCount;

  mips_run_control #(.RST_HOLD(RST_HOLD), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_mode(mode), .i_start(start),
    .i_step_count(stepCount), .i_halt_req(halt), .i_soft_rst(softRst),
    .i_cnt_clr(cntClr), .o_cpu_reset(cpuReset), .o_cpu_en(cpuEn),
    .o_busy(busy), .o_done(done), .o_cycle_count(cycleCount)
  );

  mips_run_control #(.RST_HOLD(RST_HOLD), .STEP_W(STEP_W), .CNT_W(4)) dutSmall (
    .i_clk(clk), .i_rst_n(rstN), .i_mode(mode), .i_start(start),
    .i_step_count(stepCount), .i_halt_req(halt), .i_soft_rst(softRst),
    .i_cnt_clr(cntClr), .o_cpu_reset(sCpuReset), .o_cpu_en(sCpuEn),
    .o_busy(sBusy), .o_done(sDone), .o_cycle_count(sCycleCount)
  );

  always #5 clk = ~clk;

  // Model: edges left before the core leaves reset, and enabled cycles left
  // in the current job (0 while free-running).
  int     mHoldLeft;
  bit     mReset, mEn, mDone;
  int     mLeft;
  longint mCount;
  int     mCountSmall;
  int     testCount = 0;
  int     failCount = 0;
  int     obsEn, obsDone;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelAsyncReset();
    mReset = 1; mEn = 0; mDone = 0; mLeft = 0;
    mCount = 0; mCountSmall = 0; mHoldLeft = 0;
  endtask

  task automatic modelRelease();
    mHoldLeft = RST_HOLD + 2;
  endtask

  task automatic modelEdge();
    if (cntClr) begin
      mCount = 0; mCountSmall = 0;
    end else if (mEn) begin
      if (mCount < 64'hFFFF_FFFF) mCount++;
      if (mCountSmall < 15) mCountSmall++;
    end
    mDone = 0;
    if (softRst) begin
      mReset = 1; mHoldLeft = RST_HOLD; mEn = 0; mLeft = 0;
    end else if (mReset) begin
      if (mHoldLeft > 0) mHoldLeft--;
      if (mHoldLeft == 0) mReset = 0;
    end else if (mEn) begin
      if (halt || mLeft == 1) begin
        mEn = 0; mDone = 1; mLeft = 0;
      end else if (mLeft > 1) begin
        mLeft--;
      end
    end else if (start) begin
      if (mode == 2'b01) begin
        mEn = 1; mLeft = 0;
      end else if (mode == 2'b10) begin
        if (stepCount == 0) mDone = 1;
        else begin mEn = 1; mLeft = int'(stepCount); end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".cpu_reset"}, 32'(cpuReset), 32'(mReset));
    checkOutput({tag, ".cpu_en"}, 32'(cpuEn), 32'(mEn));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(mEn));
    checkOutput({tag, ".done"}, 32'(done), 32'(mDone));
    checkOutput({tag, ".cycle_count"}, cycleCount, mCount[31:0]);
    checkOutput({tag, ".small_count"}, 32'(sCycleCount), 32'(mCountSmall));
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] m, input logic st,
                               input logic [STEP_W-1:0] n, input logic h,
                               input logic sr, input logic cc);
    mode = m; start = st; stepCount = n; halt = h; softRst = sr; cntClr = cc;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
    obsEn += int'(cpuEn);
    obsDone += int'(done);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 2'b00, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    modelAsyncReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll("reset");

    @(negedge clk);
    rstN = 1'b1;
    modelRelease();
    for (int e = 1; e <= 6; e++) begin
      idle("release", 1);
      checkOutput("release_cpu_reset", 32'(cpuReset), (e <= 5) ? 32'd1 : 32'd0);
    end

    obsEn = 0; obsDone = 0;
    applyStimulus("step3", 2'b10, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    idle("step3", 5);
    checkOutput("step3_en_cycles", 32'(obsEn), 32'd3);
    checkOutput("step3_done", 32'(obsDone), 32'd1);
    checkOutput("step3_count", cycleCount, 32'd3);

    obsEn = 0; obsDone = 0;
    applyStimulus("run10", 2'b01, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      applyStimulus("run10", 2'b01, (i == 4), 16'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus("run10", 2'b01, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("run10", 2);
    checkOutput("run10_en_cycles", 32'(obsEn), 32'd10);
    checkOutput("run10_done", 32'(obsDone), 32'd1);
    checkOutput("run10_busy", 32'(busy), 32'd0);
    checkOutput("run10_count", cycleCount, 32'd13);

    obsEn = 0; obsDone = 0;
    applyStimulus("step0", 2'b10, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("step0_done", 32'(done), 32'd1);
    idle("step0", 2);
    checkOutput("step0_en_cycles", 32'(obsEn), 32'd0);
    checkOutput("step0_done_once", 32'(obsDone), 32'd1);

    obsEn = 0; obsDone = 0;
    applyStimulus("step5h", 2'b10, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    idle("step5h", 4);
    applyStimulus("step5h", 2'b10, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("step5h", 2);
    checkOutput("step5h_en_cycles", 32'(obsEn), 32'd5);
    checkOutput("step5h_done", 32'(obsDone), 32'd1);

    applyStimulus("clr", 2'b01, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    idle("clr", 3);
    applyStimulus("clr", 2'b01, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_count", cycleCount, 32'd0);
    applyStimulus("clr", 2'b01, 1'b0, '0, 1'b1, 1'b0, 1'b0);

    applyStimulus("sat", 2'b01, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    idle("sat", 20);
    applyStimulus("sat", 2'b01, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("sat_small_count", 32'(sCycleCount), 32'd15);
    checkOutput("sat_big_count", cycleCount, 32'd21);

    obsDone = 0;
    applyStimulus("softrst", 2'b10, 1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
    idle("softrst", 3);
    applyStimulus("softrst", 2'b10, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("softrst_en", 32'(cpuEn), 32'd0);
    checkOutput("softrst_count_kept", cycleCount, 32'd25);
    for (int e = 1; e <= RST_HOLD; e++) begin
      idle("softrst", 1);
      checkOutput("softrst_cpu_reset", 32'(cpuReset), (e < RST_HOLD) ? 32'd1 : 32'd0);
    end
    checkOutput("softrst_no_done", 32'(obsDone), 32'd0);

    applyStimulus("async", 2'b01, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    idle("async", 3);
    rstN = 1'b0;
    #1;
    modelAsyncReset();
    checkAll("async");
    #2;
    rstN = 1'b1;
    modelRelease();
    idle("async", 6);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus("rand", 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                    STEP_W'($urandom_range(0, 12)), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mips_run_control.md
Name: mips_run_control

Overview:
- Parametrised clock-enable and reset sequencer driving the 5-stage MIPS pipeline core; generalises the fixed clock/reset start-up used by the pipeline.
- Stretches and synchronises reset release for the core.
- Provides the run modes halt, free-run and step-N through a core clock enable, plus an executed-cycle counter for on-board debug and self-checking benches.

Parameters:
- RST_HOLD, 4: cycles cpu_reset stays high after synchronised reset release (>=1).
- STEP_W, 16: width of step_count and the internal remaining-steps counter.
- CNT_W, 32: width of cycle_count.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2  00 halt, 01 free-run, 10 step-N, 11 reserved (treated as halt).
- start  input  1  one-cycle request, sampled only in IDLE.
- step_count  input  STEP_W  number of enabled cycles for step-N, sampled with start.
- halt_req  input  1  aborts RUN/STEP.
- soft_rst  input  1  synchronous request to re-run the reset hold sequence.
- cnt_clr  input  1  synchronous clear of cycle_count.
- cpu_reset  output  1  active-high reset to the pipeline core.
- cpu_en  output  1  registered clock enable to the pipeline core.
- busy  output  1  high in RUN or STEP.
- done  output  1  one-cycle pulse when a RUN/STEP ends or a zero-length step is requested.
- cycle_count  output  CNT_W  number of cycles with cpu_en=1.

Behaviour:
- Reset low (asynchronous): state=HOLD, sync flops=0, hold counter=0, cpu_reset=1, cpu_en=0, busy=0, done=0, cycle_count=0, remaining=0.
- Release: reset passes through a 2-flop synchroniser. Once the synchronised release is high, the hold counter counts RST_HOLD cycles.
  - cpu_reset falls on the (2+RST_HOLD)th rising edge after the first edge that samples reset high.
  - State then moves to IDLE.
- States:
  - HOLD: cpu_reset=1, cpu_en=0.
  - IDLE: cpu_en=0.
    - start=1 & mode=01 -> RUN.
    - start=1 & mode=10 & step_count!=0 -> STEP, with remaining=step_count.
    - start=1 & mode=10 & step_count==0 -> done pulse on next edge, stay IDLE.
    - start=1 with mode 00/11 -> ignored.
  - RUN: cpu_en=1 every cycle. halt_req=1 sampled at edge k -> cpu_en=0 and done=1 after edge k, state IDLE.
  - STEP: cpu_en=1 for exactly step_count consecutive cycles. remaining decrements each enabled cycle.
    - On the edge where the last step is taken, cpu_en drops, done=1 and state goes to IDLE.
    - halt_req aborts early, same timing as in RUN.
- Latency: start sampled at edge k -> cpu_en=1 from edge k (visible after edge k) for RUN/STEP. busy tracks cpu_en in RUN/STEP.
- Ignored inputs:
  - start while busy is ignored; step_count is only sampled with an accepted start.
  - halt_req outside RUN/STEP is ignored.
- Simultaneous events:
  - halt_req on the same edge as the final STEP cycle: single done pulse, no extra enabled cycle.
- soft_rst: highest synchronous priority, from any state.
  - Next edge: state=HOLD, cpu_reset=1, cpu_en=0, busy=0, done=0 (no done for the aborted run), hold counter restarts.
  - cpu_reset falls RST_HOLD edges later.
  - cycle_count is not cleared.
- cycle_count: +1 on every edge where cpu_en=1, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets it to 0 on that edge and takes priority over increment.
- Asynchronous reset assertion mid-RUN/STEP: immediate return to the reset values above; no done pulse.
- done is never high for more than one cycle. cpu_en is never high while cpu_reset=1.

Test Plan:
- RST_HOLD=4: release reset between edges -> cpu_reset=1 for edges 1-5, 0 after edge 6; cpu_en=0 throughout.
- IDLE, mode=10, step_count=3, start pulse -> cpu_en high exactly 3 cycles, done pulse on the edge cpu_en falls, cycle_count=3.
- mode=01 start, halt_req at 10th enabled cycle -> cpu_en high 10 cycles, done=1 once, busy=0 after, cycle_count=10. Then a start during RUN is ignored (repeat run with start mid-run, no restart).
- mode=10, step_count=0, start -> done pulse next cycle, cpu_en never high, state IDLE.
- Halt and counter edges:
  - STEP step_count=5 with halt_req on the 5th enabled cycle -> exactly 5 enabled cycles, one done.
  - cnt_clr with cpu_en=1 -> cycle_count=0.
  - CNT_W=4 free-run 20 cycles -> cycle_count saturates at 15.
- Resets mid-run:
  - soft_rst during STEP (remaining=7) -> cpu_en=0 next edge, cpu_reset=1 for RST_HOLD cycles, no done, cycle_count preserved.
  - Async reset low mid-RUN -> all outputs at reset values immediately.
